// File: rtl/vga_rect_fill_pkg.sv
// rtl/vga_rect_fill_pkg.sv - shared vga resolution, address/pixel widths and fill FSM encoding
package vga_rect_fill_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    localparam int HW = 10;
    localparam int VW = 9;
    localparam int PW = 24;

    typedef logic [HW-1:0] haddr_t;
    typedef logic [VW-1:0] vaddr_t;
    typedef logic [PW-1:0] pixel_t;

    // One extra bit so that x0 + w and y0 + h cannot wrap before clipping.
    typedef logic [HW:0] hsum_t;
    typedef logic [VW:0] vsum_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - solid rectangle fill engine writing clipped pixels into VRAM
module vga_rect_fill
    import vga_rect_fill_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [9:0]    i_x0,
    input  logic [8:0]    i_y0,
    input  logic [9:0]    i_w,
    input  logic [8:0]    i_h,
    input  logic [23:0]   i_color,
    input  logic          i_wready,
    output logic          o_we,
    output logic [9:0]    o_waddr_h,
    output logic [8:0]    o_waddr_v,
    output logic [23:0]   o_wdata,
    output logic          o_busy,
    output logic          o_done
);

    localparam hsum_t H_LIM = hsum_t'(H_RES);
    localparam vsum_t V_LIM = vsum_t'(V_RES);

    fill_state_t state_q, state_d;
    haddr_t      x0_q, x0_d;
    haddr_t      x_q, x_d;
    vaddr_t      y_q, y_d;
    haddr_t      x_end_q, x_end_d;
    vaddr_t      y_end_q, y_end_d;
    pixel_t      color_q, color_d;

    hsum_t x_sum, x_clip, x_last;
    vsum_t y_sum, y_clip, y_last;
    logic  empty_rect;

    // Clip the far corner of the requested rectangle to the visible area.
    always_comb begin
        x_sum      = {1'b0, i_x0} + {1'b0, i_w};
        y_sum      = {1'b0, i_y0} + {1'b0, i_h};
        x_clip     = (x_sum > H_LIM) ? H_LIM : x_sum;
        y_clip     = (y_sum > V_LIM) ? V_LIM : y_sum;
        x_last     = x_clip - hsum_t'(1);
        y_last     = y_clip - vsum_t'(1);
        empty_rect = (i_w == '0) || (i_h == '0) ||
                     ({1'b0, i_x0} >= H_LIM) || ({1'b0, i_y0} >= V_LIM);
    end

    // Next-state logic: latch the job on start, then walk the cursor row-major.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x_d     = x_q;
        y_d     = y_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        color_d = color_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    x0_d    = i_x0;
                    x_d     = i_x0;
                    y_d     = i_y0;
                    color_d = i_color;
                    x_end_d = x_last[HW-1:0];
                    y_end_d = y_last[VW-1:0];
                    state_d = empty_rect ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                // A stalled write keeps the cursor, so the address stays put.
                if (i_wready) begin
                    if (x_q < x_end_q) begin
                        x_d = x_q + haddr_t'(1);
                    end else if (y_q < y_end_q) begin
                        x_d = x0_q;
                        y_d = y_q + vaddr_t'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and job registers; reset clears everything so nothing is written afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            color_q <= color_d;
        end
    end

    assign o_we      = (state_q == ST_FILL);
    assign o_waddr_h = x_q;
    assign o_waddr_v = y_q;
    assign o_wdata   = color_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb/tb_vga_rect_fill.sv - self-checking bench for vga_rect_fill against a pixel-list model
module tb_vga_rect_fill;

    localparam int HRES = 640;
    localparam int VRES = 480;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_x0 = '0;
    logic [8:0]  i_y0 = '0;
    logic [9:0]  i_w = '0;
    logic [8:0]  i_h = '0;
    logic [23:0] i_color = '0;
    logic        i_wready = 1'b0;
    logic        o_we;
    logic [9:0]  o_waddr_h;
    logic [8:0]  o_waddr_v;
    logic [23:0] o_wdata;
    logic        o_busy;
    logic        o_done;

    int compared = 0;
    int mismatched = 0;

    vga_rect_fill #(.H_RES(HRES), .V_RES(VRES)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_x0      (i_x0),
        .i_y0      (i_y0),
        .i_w       (i_w),
        .i_h       (i_h),
        .i_color   (i_color),
        .i_wready  (i_wready),
        .o_we      (o_we),
        .o_waddr_h (o_waddr_h),
        .o_waddr_v (o_waddr_v),
        .o_wdata   (o_wdata),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " we"},    longint'(o_we),      0);
        chk({tag, " busy"},  longint'(o_busy),    0);
        chk({tag, " done"},  longint'(o_done),    0);
        chk({tag, " haddr"}, longint'(o_waddr_h), 0);
        chk({tag, " vaddr"}, longint'(o_waddr_v), 0);
        chk({tag, " wdata"}, longint'(o_wdata),   0);
    endtask

    // mode: 0 wready high, 1 wready toggling 1,0,..., 2 random wready.
    // noise: scribble inputs and re-request start during the fill.
    // abort_after: assert reset once this many writes were accepted (-1 = never).
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input int color, input int mode, input bit noise,
                            input int abort_after);
        int exp_q[$];
        int budget;
        int cyc;
        int nwr;
        int got;
        bit done_seen;
        bit aborted;
        // Reference: every visible pixel of the rectangle, row-major.
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                if (xx < HRES && yy < VRES) exp_q.push_back(yy * 1024 + xx);
        budget = 8 * exp_q.size() + 20;
        @(negedge i_clk);
        i_x0 = 10'(x0); i_y0 = 9'(y0); i_w = 10'(w); i_h = 9'(h);
        i_color = 24'(color); i_start = 1'b1; i_wready = 1'b1;
        cyc = 0; nwr = 0; done_seen = 0; aborted = 0;
        while (cyc < budget && !done_seen && !aborted) begin
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            if (noise) begin
                i_x0 = 10'($urandom); i_y0 = 9'($urandom); i_w = 10'($urandom);
                i_h = 9'($urandom); i_color = 24'($urandom);
                i_start = 1'($urandom);
            end
            if (o_done) begin
                done_seen = 1;
                i_start = 1'b0;
                chk("done we low", longint'(o_we), 0);
                chk("done busy", longint'(o_busy), 1);
                chk("writes at done", nwr, exp_q.size() + nwr - exp_q.size());
            end else begin
                case (mode)
                    0: i_wready = 1'b1;
                    1: i_wready = (cyc % 2) == 1;
                    default: i_wready = ($urandom_range(0, 3) != 0);
                endcase
                if (!o_we) begin
                    chk("we during fill", longint'(o_we), 1);
                    aborted = 1;
                end else if (i_wready) begin
                    got = int'(o_waddr_v) * 1024 + int'(o_waddr_h);
                    if (exp_q.size() == 0) begin
                        chk("extra write", got, -1);
                    end else begin
                        chk("write addr", got, exp_q.pop_front());
                        chk("write data", longint'(o_wdata), color);
                    end
                    nwr++;
                    if (nwr == abort_after) begin
                        #2 i_rst = 1'b1;
                        #1 check_all_zero("async reset");
                        @(negedge i_clk);
                        i_rst = 1'b0;
                        i_start = 1'b0;
                        for (int k = 0; k < 10; k++) begin
                            @(negedge i_clk);
                            chk("post reset quiet",
                                longint'({o_we, o_busy, o_done}), 0);
                        end
                        aborted = 1;
                    end
                end
            end
        end
        if (abort_after < 0) begin
            chk("done seen", longint'(done_seen), 1);
            chk("all pixels written", exp_q.size(), 0);
            if (mode == 0 && done_seen) chk("latency", cyc, nwr + 1);
            @(negedge i_clk);
            chk("done one cycle", longint'(o_done), 0);
            chk("idle after done", longint'(o_busy), 0);
        end
        i_start = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("idle after reset");

        run_fill(10, 20, 3, 2, 24'hFF0000, 0, 0, -1);
        run_fill(10, 20, 3, 2, 24'hFF0000, 1, 0, -1);
        run_fill(638, 478, 5, 5, 24'h00FF00, 0, 0, -1);
        run_fill(100, 100, 0, 4, 24'h123456, 0, 0, -1);
        run_fill(640, 10, 4, 4, 24'h123456, 0, 0, -1);
        run_fill(5, 480, 4, 4, 24'h654321, 0, 0, -1);
        run_fill(200, 50, 4, 3, 24'h0000FF, 0, 1, -1);
        run_fill(30, 40, 4, 4, 24'hABCDEF, 0, 0, 5);
        run_fill(30, 40, 4, 4, 24'hABCDEF, 0, 0, -1);
        run_fill(0, 0, 1, 1, 24'hFFFFFF, 0, 0, -1);

        for (int t = 0; t < 25; t++) begin
            int x0, y0;
            x0 = ($urandom_range(0, 2) == 0) ? $urandom_range(625, 660) : $urandom_range(0, 639);
            y0 = ($urandom_range(0, 2) == 0) ? $urandom_range(465, 500) : $urandom_range(0, 479);
            run_fill(x0, y0, $urandom_range(0, 14), $urandom_range(0, 14),
                     $urandom_range(0, 24'hFFFFFF), $urandom_range(0, 2),
                     1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
